// File: rtl/divider_pkg.sv
// divider_pkg: shared width, FSM state type and divide-by-zero constants (DIVIDER_DBZ_EARLY_EN)
package divider_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, ITER, FIXUP} div_state_t;
  localparam logic [DIV_WIDTH-1:0] DBZ_Q_POS = '1;
  localparam logic [DIV_WIDTH-1:0] DBZ_Q_NEG = DIV_WIDTH'(1);
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational radix-2 restoring step on unsigned magnitudes
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] partial;
  // shift the next dividend bit in and subtract when the divisor fits
  always_comb begin
    partial = {rem_i, msb_i};
    q_o     = partial >= {1'b0, dvs_i};
    rem_o   = q_o ? partial[WIDTH-1:0] - dvs_i : partial[WIDTH-1:0];
  end
endmodule

// File: rtl/divider.sv
// divider: sequential MIPS DIV/DIVU, LO=quotient HI=remainder; DIVIDER_DBZ_EARLY_EN short-cuts divide-by-zero
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  output logic [WIDTH-1:0] hi_output,
  output logic [WIDTH-1:0] lo_output,
  output logic             stall
);
  div_state_t       state_q, state_d;
  logic             sgn_q, sgn_d, dneg_q, dneg_d, vneg_q, vneg_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] abs_1, abs_2;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .msb_i(dvd_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  assign abs_1     = (signed_op && input_1[WIDTH-1]) ? -input_1 : input_1;
  assign abs_2     = (signed_op && input_2[WIDTH-1]) ? -input_2 : input_2;
  assign stall     = reset && ((state_q == IDLE && start) || state_q != IDLE);
  assign hi_output = hi_q;
  assign lo_output = lo_q;

  // next-state: latch magnitudes, iterate, then apply signs to the results
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    dneg_d  = dneg_q;
    vneg_d  = vneg_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start) begin
        sgn_d   = signed_op;
        dneg_d  = input_1[WIDTH-1];
        vneg_d  = input_2[WIDTH-1];
        dvd_d   = abs_1;
        dvs_d   = abs_2;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
`ifdef DIVIDER_DBZ_EARLY_EN
        if (input_2 == '0) begin
          dvd_d   = DBZ_Q_POS;
          rem_d   = abs_1;
          state_d = FIXUP;
        end
`endif
      end
      ITER: begin
        rem_d   = step_rem;
        dvd_d   = {dvd_q[WIDTH-2:0], step_q};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FIXUP : ITER;
      end
      FIXUP: begin
        lo_d    = (sgn_q && (dneg_q ^ vneg_q)) ? -dvd_q : dvd_q;
        hi_d    = (sgn_q && dneg_q) ? -rem_q : rem_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous active-low reset that dominates everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      dneg_q  <= 1'b0;
      vneg_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      dneg_q  <= dneg_d;
      vneg_q  <= vneg_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
